// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master and the SRAM slave.
// HREADY is the bus-level ready, driven on the master side.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE,
        output HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE,
        input  HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave with byte lanes,
// programmable wait states and two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int AW          = 8,
    parameter int WAIT_STATES = 1
) (
    input logic             HCLK,
    input logic             HRESET,
    ahb_sram_slave_if.slave bus
);
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
        $error("WAIT_STATES must be 0..15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state;
    state_t state_nx;
    state_t go_st;

    logic [3:0]    cnt;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic          wr;
    logic [31:0]   rdata;
    logic [31:0]   mem [2**AW];

    logic          open_ph;
    logic          go;
    logic          illegal;
    logic          size_bad;
    logic          hi_bad;
    logic [AW-1:0] widx_nx;
    logic [3:0]    be_nx;
    logic          commit;
    logic [31:0]   wmerge;
    logic [31:0]   rd_nx;
    logic          rdy;
    logic          resp;
    logic          unused;

    assign unused  = ^{bus.HBURST, bus.HTRANS[0]};
    assign widx_nx = bus.HADDR[AW+1:2];
    assign hi_bad  = |bus.HADDR[31:AW+2];

    assign size_bad = (bus.HSIZE > 3'd2)
        | (bus.HSIZE == 3'd1 & bus.HADDR[0])
        | (bus.HSIZE == 3'd2 & |bus.HADDR[1:0]);

    assign illegal = hi_bad | size_bad;

    // New phases are only taken where the slave shows ready.
    assign open_ph = (state == S_IDLE)
        | (state == S_DATA)
        | (state == S_ERR2);

    assign go = bus.HSEL & bus.HREADY
        & bus.HTRANS[1] & open_ph;

    always_comb begin
        be_nx = 4'b0000;
        unique case (1'b1)
            bus.HSIZE == 3'd0:
                be_nx = 4'b0001 << bus.HADDR[1:0];
            bus.HSIZE == 3'd1:
                be_nx = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default:
                be_nx = 4'b1111;
        endcase
    end

    assign commit = (state == S_DATA) & wr;

    always_comb begin
        wmerge = mem[widx];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                wmerge[8*b +: 8] = bus.HWDATA[8*b +: 8];
            end
        end
    end

    // Read accepted on the commit edge of the same word sees new bytes.
    assign rd_nx = (commit && widx == widx_nx)
        ? wmerge : mem[widx_nx];

    always_comb begin
        go_st = S_IDLE;
        if (go) begin
            if (illegal) begin
                go_st = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                go_st = S_WAIT;
            end else begin
                go_st = S_DATA;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nx = S_DATA;
                end
            end
            S_ERR1:  state_nx = S_ERR2;
            default: state_nx = go_st;
        endcase
    end

    always_comb begin
        rdy  = 1'b1;
        resp = 1'b0;
        unique case (state)
            S_WAIT: rdy = 1'b0;
            S_ERR1: begin
                rdy  = 1'b0;
                resp = 1'b1;
            end
            S_ERR2:  resp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt   <= '0;
            widx  <= '0;
            be    <= '0;
            wr    <= 1'b0;
            rdata <= '0;
        end else begin
            if (go && !illegal) begin
                cnt <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (go) begin
                widx <= widx_nx;
                be   <= be_nx;
                wr   <= bus.HWRITE;
            end
            if (go && !illegal && !bus.HWRITE) begin
                rdata <= rd_nx;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            mem[widx] <= wmerge;
        end
    end

    assign bus.HREADYOUT = rdy;
    assign bus.HRESP     = resp;
    assign bus.HRDATA    = rdata;
endmodule
